// File: rtl/count_sequencer.sv
// Command-driven sequencer for an 8-bit loadable counter: presets the counter,
// enables it until its output reaches the terminal value, then reports status.
module count_sequencer #(
  parameter int WIDTH       = 8,
  parameter int WDOG_CYCLES = 260
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  input  logic [WIDTH-1:0] i_cmd_start,
  input  logic [WIDTH-1:0] i_cmd_end,
  output logic             o_cmd_ready,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_count_in,
  output logic             o_load,
  output logic             o_enable,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_status
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ABORTED = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam int              WD_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_start_q;
  logic [WIDTH-1:0] r_end_q;
  logic [1:0]       r_status;
  logic [WD_W-1:0]  r_wdog;

  logic w_handshake;
  logic w_match;
  logic w_expire;

  assign w_handshake = i_cmd_valid && o_cmd_ready;
  assign w_match     = (i_count_in == r_end_q);
  assign w_expire    = (r_wdog == WD_LAST);

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_start_q <= '0;
      r_end_q   <= '0;
      r_status  <= ST_OK;
      r_wdog    <= '0;
    end else begin
      r_state <= w_next_state;
      r_wdog  <= (r_state == S_RUN) ? r_wdog + WD_W'(1) : '0;
      if (w_handshake) begin
        r_start_q <= i_cmd_start;
        r_end_q   <= i_cmd_end;
        r_status  <= ST_OK;
      end
      // Abort outranks match, and match outranks watchdog expiry.
      if ((r_state == S_LOAD || r_state == S_RUN) && i_abort)
        r_status <= ST_ABORTED;
      else if (r_state == S_RUN && w_match)
        r_status <= ST_OK;
      else if (r_state == S_RUN && w_expire)
        r_status <= ST_TIMEOUT;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_handshake) w_next_state = S_LOAD;
      S_LOAD:  w_next_state = i_abort ? S_DONE : S_RUN;
      S_RUN:   if (i_abort || w_match || w_expire) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_cmd_ready = 1'b0;
    o_load      = 1'b0;
    o_enable    = 1'b0;
    o_done      = 1'b0;
    o_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  o_cmd_ready = !i_reset;
      S_LOAD:  o_load      = !i_abort;
      S_RUN:   o_enable    = !i_abort && !w_match;
      S_DONE:  o_done      = 1'b1;
      default: ;
    endcase
  end

  assign o_data_out = r_start_q;
  assign o_status   = r_status;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: behavioural counter in the loop and a
// scoreboard of expected completions popped whenever done pulses.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [7:0] cmd_start;
  logic [7:0] cmd_end;
  logic       cmd_ready;
  logic       abort;
  logic [7:0] count_in;
  logic       load;
  logic       enable;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  logic [1:0] status;

  count_sequencer #(.WIDTH(8), .WDOG_CYCLES(260)) dut (
    .clk(clk), .i_reset(reset), .i_cmd_valid(cmd_valid), .i_cmd_start(cmd_start),
    .i_cmd_end(cmd_end), .o_cmd_ready(cmd_ready), .i_abort(abort), .i_count_in(count_in),
    .o_load(load), .o_enable(enable), .o_data_out(data_out), .o_busy(busy),
    .o_done(done), .o_status(status)
  );

  always #5 clk = ~clk;

  // Counter model; 'stuck' makes it ignore enable for the watchdog scenario.
  logic [7:0] cnt = 8'd0;
  bit         stuck = 1'b0;
  always @(posedge clk) begin
    if (load) cnt <= data_out;
    else if (enable && !stuck) cnt <= cnt + 8'd1;
  end
  assign count_in = cnt;

  typedef struct {
    logic [7:0] start;
    logic [1:0] status;
    int         lat;
    int         en_cycles;
    logic [7:0] final_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  bit         active = 1'b0;
  int         cyc, en_cnt, ld_cnt;
  logic [7:0] ld_data;
  int         hs_count = 0;
  int         done_count = 0;
  logic       s_busy, s_ready;

  // Samples the DUT at the falling edge and retires scoreboard entries on done.
  task automatic monitor();
    exp_t e;
    s_busy  = busy;
    s_ready = cmd_ready;
    if (reset) begin
      active = 1'b0;
      return;
    end
    if (active) begin
      cyc++;
      if (enable) en_cnt++;
      if (load) begin
        ld_cnt++;
        ld_data = data_out;
      end
    end
    if (done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: done=1 with no command outstanding (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (status !== e.status) begin
          n_err++; $display("FAIL status[start=%0d]: got %b want %b", e.start, status, e.status);
        end
        n_cmp++;
        if (cyc !== e.lat) begin
          n_err++; $display("FAIL latency[start=%0d]: got %0d want %0d", e.start, cyc, e.lat);
        end
        n_cmp++;
        if (en_cnt !== e.en_cycles) begin
          n_err++; $display("FAIL enable_cycles[start=%0d]: got %0d want %0d", e.start, en_cnt, e.en_cycles);
        end
        n_cmp++;
        if (count_in !== e.final_cnt) begin
          n_err++; $display("FAIL final_count[start=%0d]: got %0d want %0d", e.start, count_in, e.final_cnt);
        end
        n_cmp++;
        if (ld_cnt !== 1 || ld_data !== e.start) begin
          n_err++; $display("FAIL load_pulse[start=%0d]: got %0d pulses data %0d want 1 pulse data %0d",
                            e.start, ld_cnt, ld_data, e.start);
        end
      end
      active = 1'b0;
    end
    if (cmd_valid && cmd_ready) begin
      hs_count++;
      active  = 1'b1;
      cyc     = -1;
      en_cnt  = 0;
      ld_cnt  = 0;
      ld_data = 8'hxx;
    end
  endtask

  // One clock: sample at the falling edge, return just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] s, input logic [1:0] st, input int lat,
                          input int en, input logic [7:0] fin);
    exp_t e;
    e.start = s; e.status = st; e.lat = lat; e.en_cycles = en; e.final_cnt = fin;
    exp_q.push_back(e);
  endtask

  // Drives a command and returns just after its handshake edge.
  task automatic issue_cmd(input logic [7:0] s, input logic [7:0] e, input bit hold);
    int hs0;
    int n;
    hs0 = hs_count;
    cmd_valid = 1'b1; cmd_start = s; cmd_end = e;
    n = 0;
    while (hs_count == hs0 && n < 20) begin
      cycle();
      n++;
    end
    if (hs_count == hs0) begin
      n_cmp++; n_err++;
      $display("FAIL handshake[start=%0d]: not accepted within %0d cycles", s, n);
    end
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      cycle();
      n++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d completions missing after %0d cycles", exp_q.size(), limit);
      exp_q.delete();
    end
    cycle();
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++;
    if ({load, enable, data_out, busy, done, status, cmd_ready} !== 15'd0) begin
      n_err++;
      $display("FAIL %s: got load=%b en=%b data=%0d busy=%b done=%b status=%b ready=%b want all 0",
               tag, load, enable, data_out, busy, done, status, cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    check_reset_values("reset_values");
    reset = 1'b0;
    cycle();
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset: got ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic();
    push_exp(8'd10, 2'b00, 5, 3, 8'd13);
    issue_cmd(8'd10, 8'd13, 1'b0);
    drain(20);
  endtask

  task automatic test_wrap();
    push_exp(8'd254, 2'b00, 5, 3, 8'd1);
    issue_cmd(8'd254, 8'd1, 1'b0);
    drain(20);
  endtask

  task automatic test_equal();
    push_exp(8'd7, 2'b00, 2, 0, 8'd7);
    issue_cmd(8'd7, 8'd7, 1'b0);
    drain(20);
  endtask

  task automatic test_abort();
    push_exp(8'd0, 2'b01, 6, 4, 8'd4);
    issue_cmd(8'd0, 8'd200, 1'b0);
    repeat (5) cycle();
    abort = 1'b1;
    #1;
    n_cmp++;
    if (enable !== 1'b0 || load !== 1'b0) begin
      n_err++; $display("FAIL abort_forces_low: got en=%b load=%b want 0 0", enable, load);
    end
    cycle();
    abort = 1'b0;
    drain(20);
  endtask

  task automatic test_timeout();
    stuck = 1'b1;
    push_exp(8'd5, 2'b10, 261, 260, 8'd5);
    issue_cmd(8'd5, 8'd6, 1'b0);
    drain(300);
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    issue_cmd(8'd0, 8'd200, 1'b0);
    repeat (6) cycle();
    reset = 1'b1;
    cycle();
    check_reset_values("reset_mid_run");
    reset = 1'b0;
    repeat (5) cycle();
  endtask

  task automatic test_back_to_back();
    int d0;
    int hs1;
    int n;
    push_exp(8'd20, 2'b00, 4, 2, 8'd22);
    issue_cmd(8'd20, 8'd22, 1'b1);
    push_exp(8'd30, 2'b00, 3, 1, 8'd31);
    cmd_start = 8'd30; cmd_end = 8'd31;
    d0 = done_count;
    n = 0;
    while (done_count == d0 && n < 20) begin
      cycle();
      n++;
      n_cmp++;
      if (s_busy && s_ready !== 1'b0) begin
        n_err++; $display("FAIL ready_while_busy: got %b want 0", s_ready);
      end
    end
    hs1 = hs_count;
    cycle();
    n_cmp++;
    if (hs_count !== hs1 + 1) begin
      n_err++; $display("FAIL back_to_back_accept: got %0d handshakes want %0d", hs_count - hs1, 1);
    end
    cmd_valid = 1'b0;
    drain(20);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_start = '0; cmd_end = '0; abort = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_equal();
    test_abort();
    test_reset_mid_run();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Command-driven controller that sits directly upstream of the 8-bit smart counter. It accepts a (start, end) command over a valid/ready handshake and presets the counter through its `load`/`data_in` pins. It then drives `enable` until the counter's `count_out`, fed back on `count_in`, equals the end value, and reports completion, abort or timeout with a one-cycle `done` pulse plus a sticky status code.

## Interface

Parameters:
- `WIDTH`, 8 — counter/data width; must match the counter.
- `WDOG_CYCLES`, 260 — maximum cycles in RUN before timeout; must exceed 2^WIDTH.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — synchronous, active-high.
- `cmd_valid`  in  1  — command present.
- `cmd_start`  in  WIDTH  — preset value.
- `cmd_end`  in  WIDTH  — terminal count.
- `cmd_ready`  out  1  — command can be accepted.
- `abort`  in  1  — cancel the current command.
- `count_in`  in  WIDTH  — from the counter's `count_out`.
- `load`  out  1  — to the counter's `load`.
- `enable`  out  1  — to the counter's `enable`.
- `data_out`  out  WIDTH  — to the counter's `data_in`.
- `busy`  out  1  — state != IDLE.
- `done`  out  1  — one-cycle completion pulse.
- `status`  out  2  — 00 ok, 01 aborted, 10 timeout; sticky.

## Operation

**Counter contract.** On an edge with `load=1`, the counter takes `data_in`. On an edge with `enable=1, load=0`, it increments mod 2^WIDTH. The new value appears on `count_in` in the following cycle.

**FSM states:** IDLE, LOAD, RUN, DONE.
- **IDLE:** `cmd_ready=1` (forced 0 while `reset`=1).
  - Handshake when `cmd_valid&cmd_ready` at an edge: latch start/end, clear `status` to 00, go to LOAD.
  - `cmd_valid` with `cmd_ready=0` is ignored; the source must hold it.
- **LOAD:** one cycle. `load=1`, `data_out=start_q`, `enable=0`. Next state is RUN.
- **RUN:**
  - `enable = (count_in != end_q)` (combinational). This guarantees no overshoot.
  - When `count_in == end_q`, go to DONE with status 00.
  - The watchdog counts RUN cycles. At `WDOG_CYCLES` without a match, go to DONE with status 10.
- **DONE:** `done=1` for exactly one cycle, `enable=0`, `load=0`. Next state is IDLE.
- **Abort:** `abort=1` in LOAD or RUN takes priority over match and timeout.
  - `load` and `enable` are forced to 0 in that cycle.
  - Next state is DONE with status 01.
  - In IDLE or DONE, `abort` is ignored.
- **Outputs outside their states:**
  - `data_out` holds `start_q` (0 after reset).
  - `load` and `enable` are 0 outside LOAD and RUN respectively.
- **Wrap-around:** `end < start` is legal. The counter wraps 255→0, and RUN lasts ((end − start) mod 2^WIDTH) + 1 cycles.
- **start == end:** RUN lasts 1 cycle with `enable=0`. The counter is never incremented.

## Timing

- **Reset values:** state=IDLE, `load=0`, `enable=0`, `data_out=0`, `busy=0`, `done=0`, `status=00`, `cmd_ready=0` while `reset` is high.
- **Reset mid-operation:** the next edge returns to IDLE with reset values. No `done` pulse is issued.
- **Cycle-level sequence:**
  - Handshake edge E0.
  - Cycle after E0: LOAD (`load=1`).
  - Edge E1: counter loads.
  - Cycle after E1: RUN with `count_in=start`.
- **Latency:** with k = (end − start) mod 2^WIDTH, `done` is high k+2 cycles after E0. The next handshake is possible the cycle after `done`.
- **Simultaneous events:**
  - `abort` and match in the same RUN cycle gives status 01.
  - Match and watchdog expiry in the same cycle gives status 00 (match wins over timeout).
- `status` is stable from `done` until the next accepted command.

## Test plan

- **Basic run:** reset 2 cycles, command start=10, end=13.
  - Required response: one `load` pulse with `data_out`=10, `enable` high 3 cycles, `count_in` ends at 13.
  - `done` high 5 cycles after the handshake; `status`=00.
- **Wrap:** start=254, end=1.
  - Required response: `enable` high 3 cycles, counter sequence 254,255,0,1, `status`=00.
- **Equal values:** start=end=7.
  - Required response: `enable` never asserted, `done` 2 cycles after the handshake, `status`=00.
- **Abort:** start=0, end=200; assert `abort` on the 5th RUN cycle.
  - Required response: `enable` drops in that cycle, `done` on the next cycle, `status`=01, counter holds 4.
- **Timeout:** counter model with `enable` ignored (stuck at 5); command start=5, end=6.
  - Required response: `done` after 260 RUN cycles, `status`=10.
- **Reset and back-to-back:**
  - Reset asserted mid-RUN: the next cycle shows all outputs at reset values with no `done`.
  - `cmd_valid` held continuously: `cmd_ready` drops while busy, and a second command is accepted the cycle after the first `done`.
